axis_video_frame_monitor: RTL and testbench

- Synthesizable, passive AXI4-Stream video monitor. Taps a video stream (tdata/tuser/tlast/tvalid/tready) without driving it.
- Measures active width and height per frame and compares them with programmed expected values.
- Reports per-frame completion, pass/fail status, sticky error flags and a frame counter.
- Sits beside the TPG/VDMA output in the BD; replaces bench-only size counting with in-fabric checking that works in both simulation and ILA-probed hardware.

---
 rtl/axis_video_frame_monitor.sv | 248 ++++++++++++++++++++++++
 tb/tb_axis_video_frame_monitor.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/axis_video_frame_monitor.sv
// Passive AXI4-Stream video monitor: measures line width and frame height, flags framing errors.
// Define AXIS_VIDEO_MON_CHECKSUM_EN to build the per-frame tdata checksum; otherwise frame_checksum is 0.
module axis_video_frame_monitor #(
  parameter int DATA_W = 24,
  parameter int PPC    = 1,
  parameter int DIM_W  = 16,
  parameter int FCNT_W = 32
) (
  input  logic              aclk,
  input  logic              aresetn,
  input  logic [DATA_W-1:0] mon_tdata,
  input  logic              mon_tuser,
  input  logic              mon_tlast,
  input  logic              mon_tvalid,
  input  logic              mon_tready,
  input  logic              enable,
  input  logic [DIM_W-1:0]  exp_width,
  input  logic [DIM_W-1:0]  exp_height,
  input  logic              clr_err,
  output logic              frame_done,
  output logic              frame_ok,
  output logic [DIM_W-1:0]  meas_width,
  output logic [DIM_W-1:0]  meas_height,
  output logic [FCNT_W-1:0] frame_count,
  output logic [4:0]        err_flags,
  output logic [31:0]       frame_checksum
);

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_WAIT_SOF = 2'd1,
    ST_ACTIVE   = 2'd2
  } state_t;

  localparam logic [DIM_W-1:0] PPC_DIM  = DIM_W'(PPC);
  localparam logic [DIM_W-1:0] DIM_ONES = {DIM_W{1'b1}};
  localparam logic [DIM_W-1:0] DIM_ZERO = {DIM_W{1'b0}};
  localparam logic [DIM_W-1:0] DIM_ONE  = DIM_W'(1);

  state_t           state_r;
  state_t           state_nx_s;
  logic             run_wait_s;
  logic             run_active_s;
  logic             xfer_s;
  logic             start_s;
  logic             early_close_s;
  logic             beat_s;
  logic             in_frame_s;
  logic             line_eol_s;
  logic             eol_close_s;
  logic             short_s;
  logic             long_s;
  logic             sat_s;
  logic [DIM_W:0]   pix_sum_s;
  logic [DIM_W-1:0] pix_now_s;
  logic [DIM_W-1:0] ew_s;
  logic [DIM_W-1:0] eh_s;
  logic [DIM_W-1:0] base_line_s;
  logic [DIM_W-1:0] line_inc_s;
  logic [4:0]       base_err_s;
  logic [4:0]       frame_err_now_s;
  logic [4:0]       err_set_s;
  logic [DIM_W-1:0] pix_cnt_r;
  logic [DIM_W-1:0] line_cnt_r;
  logic [DIM_W-1:0] exp_w_r;
  logic [DIM_W-1:0] exp_h_r;
  logic [4:0]       frame_err_r;

  // Adds PPC to the pixel count; MSB of the result flags saturation at all-ones.
  function automatic logic [DIM_W:0] sat_add(input logic [DIM_W-1:0] a);
    logic [DIM_W:0] s;
    s = {1'b0, a} + {1'b0, PPC_DIM};
    if (s[DIM_W]) begin
      sat_add = {1'b1, DIM_ONES};
    end else begin
      sat_add = {1'b0, s[DIM_W-1:0]};
    end
  endfunction

  // State register.
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nx_s;
    end
  end

  // Next-state logic; dropping enable aborts from any state.
  always_comb begin
    state_nx_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (enable) begin
          state_nx_s = ST_WAIT_SOF;
        end else begin
          state_nx_s = ST_IDLE;
        end
      end
      ST_WAIT_SOF, ST_ACTIVE: begin
        if (!enable) begin
          state_nx_s = ST_IDLE;
        end else if (eol_close_s) begin
          state_nx_s = ST_WAIT_SOF;
        end else if (start_s) begin
          state_nx_s = ST_ACTIVE;
        end else begin
          state_nx_s = state_r;
        end
      end
      default: state_nx_s = ST_IDLE;
    endcase
  end

  // State decode into run qualifiers.
  always_comb begin
    run_wait_s   = 1'b0;
    run_active_s = 1'b0;
    case (state_r)
      ST_WAIT_SOF: run_wait_s   = enable;
      ST_ACTIVE:   run_active_s = enable;
      default: begin
        run_wait_s   = 1'b0;
        run_active_s = 1'b0;
      end
    endcase
  end

  // Beat evaluation: an SOF beat opens a fresh frame context before its EOL is judged.
  always_comb begin
    xfer_s        = mon_tvalid & mon_tready;
    start_s       = (run_wait_s | run_active_s) & xfer_s & mon_tuser;
    early_close_s = run_active_s & xfer_s & mon_tuser;
    beat_s        = run_active_s & xfer_s & ~mon_tuser;
    in_frame_s    = start_s | beat_s;
    pix_sum_s     = sat_add(pix_cnt_r);
    if (start_s) begin
      ew_s        = exp_width;
      eh_s        = exp_height;
      base_line_s = DIM_ZERO;
      base_err_s  = 5'b00000;
      pix_now_s   = PPC_DIM;
      sat_s       = 1'b0;
    end else begin
      ew_s        = exp_w_r;
      eh_s        = exp_h_r;
      base_line_s = line_cnt_r;
      base_err_s  = frame_err_r;
      if (beat_s) begin
        pix_now_s = pix_sum_s[DIM_W-1:0];
        sat_s     = pix_sum_s[DIM_W];
      end else begin
        pix_now_s = pix_cnt_r;
        sat_s     = 1'b0;
      end
    end
    line_eol_s      = in_frame_s & mon_tlast;
    short_s         = line_eol_s & (pix_now_s < ew_s);
    long_s          = line_eol_s & (pix_now_s > ew_s);
    line_inc_s      = base_line_s + DIM_ONE;
    eol_close_s     = line_eol_s & (line_inc_s == eh_s);
    frame_err_now_s = base_err_s | {sat_s, 1'b0, 1'b0, long_s, short_s};
    err_set_s       = {sat_s, run_wait_s & xfer_s & ~mon_tuser, early_close_s, long_s, short_s};
  end

  // Frame counters, measurements and error flags.
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      frame_done  <= 1'b0;
      frame_ok    <= 1'b0;
      meas_width  <= DIM_ZERO;
      meas_height <= DIM_ZERO;
      frame_count <= {FCNT_W{1'b0}};
      err_flags   <= 5'b00000;
      pix_cnt_r   <= DIM_ZERO;
      line_cnt_r  <= DIM_ZERO;
      exp_w_r     <= DIM_ZERO;
      exp_h_r     <= DIM_ZERO;
      frame_err_r <= 5'b00000;
    end else begin
      frame_done  <= early_close_s | eol_close_s;
      // A 1-line frame started by an early SOF can close twice in one beat.
      frame_count <= frame_count + FCNT_W'(early_close_s) + FCNT_W'(eol_close_s);
      if (eol_close_s) begin
        meas_height <= line_inc_s;
        frame_ok    <= ~|frame_err_now_s;
      end else if (early_close_s) begin
        meas_height <= line_cnt_r;
        frame_ok    <= 1'b0;
      end
      if (line_eol_s) begin
        meas_width <= pix_now_s;
      end
      if (clr_err) begin
        err_flags <= err_set_s;
      end else begin
        err_flags <= err_flags | err_set_s;
      end
      if (in_frame_s) begin
        exp_w_r     <= ew_s;
        exp_h_r     <= eh_s;
        pix_cnt_r   <= line_eol_s ? DIM_ZERO : pix_now_s;
        line_cnt_r  <= line_eol_s ? line_inc_s : base_line_s;
        frame_err_r <= frame_err_now_s;
      end
    end
  end

`ifdef AXIS_VIDEO_MON_CHECKSUM_EN
  logic [31:0] csum_acc_r;
  logic [31:0] csum_nx_s;

  function automatic logic [31:0] zext32(input logic [DATA_W-1:0] d);
    zext32 = 32'(d);
  endfunction

  // Running tdata sum, restarted by the SOF beat.
  always_comb begin
    if (start_s) begin
      csum_nx_s = zext32(mon_tdata);
    end else if (beat_s) begin
      csum_nx_s = csum_acc_r + zext32(mon_tdata);
    end else begin
      csum_nx_s = csum_acc_r;
    end
  end

  // Accumulator and checksum latch on frame close.
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      csum_acc_r     <= 32'd0;
      frame_checksum <= 32'd0;
    end else begin
      csum_acc_r <= csum_nx_s;
      if (eol_close_s) begin
        frame_checksum <= csum_nx_s;
      end else if (early_close_s) begin
        frame_checksum <= csum_acc_r;
      end
    end
  end
`else
  logic unused_tdata;
  assign unused_tdata   = ^mon_tdata;
  assign frame_checksum = 32'd0;
`endif

endmodule

// File: tb/tb_axis_video_frame_monitor.sv
// Self-checking bench for axis_video_frame_monitor: vector table, directed corner sequences
// and randomized frames checked against a frame-level reference model.
module tb_axis_video_frame_monitor;

  logic        aclk = 1'b0;
  logic        aresetn, tuser, tlast, tvalid, tready, enable, clr_err;
  logic [23:0] tdata;
  logic [15:0] exp_width1, exp_width2, exp_height;

  logic        done1, ok1, done2, ok2;
  logic [15:0] mw1, mh1, mw2, mh2;
  logic [31:0] fc1, fc2, cs1, cs2;
  logic [4:0]  err1, err2;

  always #5 aclk = ~aclk;

  axis_video_frame_monitor #(.DATA_W(24), .PPC(1), .DIM_W(16), .FCNT_W(32)) dut1 (
    .aclk(aclk), .aresetn(aresetn), .mon_tdata(tdata), .mon_tuser(tuser), .mon_tlast(tlast),
    .mon_tvalid(tvalid), .mon_tready(tready), .enable(enable), .exp_width(exp_width1),
    .exp_height(exp_height), .clr_err(clr_err), .frame_done(done1), .frame_ok(ok1),
    .meas_width(mw1), .meas_height(mh1), .frame_count(fc1), .err_flags(err1),
    .frame_checksum(cs1));

  axis_video_frame_monitor #(.DATA_W(48), .PPC(2), .DIM_W(16), .FCNT_W(32)) dut2 (
    .aclk(aclk), .aresetn(aresetn), .mon_tdata({24'd0, tdata}), .mon_tuser(tuser), .mon_tlast(tlast),
    .mon_tvalid(tvalid), .mon_tready(tready), .enable(enable), .exp_width(exp_width2),
    .exp_height(exp_height), .clr_err(clr_err), .frame_done(done2), .frame_ok(ok2),
    .meas_width(mw2), .meas_height(mh2), .frame_count(fc2), .err_flags(err2),
    .frame_checksum(cs2));

  typedef struct { int mw; int mh; bit ok; int fc; } rec_t;
  typedef struct { int ew; int eh; int nl; int ll; int mw; int mh; bit ok; logic [4:0] err; } vec_t;

  rec_t obs1[$];
  int   n_chk = 0;
  int   n_fail = 0;
  int   dcnt = 0;
  bit   ready_rand = 1'b0;

  // Every frame_done pulse of the PPC=1 monitor is logged with its outputs.
  always @(negedge aclk) begin
    if (done1) obs1.push_back('{int'(mw1), int'(mh1), ok1, int'(fc1)});
  end

  task automatic chk(input string name, input longint got, input longint exp);
    n_chk++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  task automatic chk_rec(input string name, input int idx, input int mw, input int mh,
                         input bit ok, input int fc);
    chk({name, "_present"}, longint'(obs1.size() > idx), 1);
    if (obs1.size() > idx) begin
      chk({name, "_mw"}, obs1[idx].mw, mw);
      chk({name, "_mh"}, obs1[idx].mh, mh);
      chk({name, "_ok"}, obs1[idx].ok, ok);
      chk({name, "_fc"}, obs1[idx].fc, fc);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge aclk);
      #1;
    end
  endtask

  task automatic do_reset();
    aresetn = 1'b0; enable = 1'b0; clr_err = 1'b0;
    tvalid = 1'b0; tready = 1'b0; tuser = 1'b0; tlast = 1'b0;
    idle(1);
    aresetn = 1'b1; enable = 1'b1;
    idle(1);
  endtask

  task automatic send_beat(input logic [23:0] d, input bit u, input bit l);
    bit hs;
    int n;
    if (ready_rand && $urandom_range(0, 3) == 0) begin
      tvalid = 1'b0; tuser = 1'($urandom_range(0, 1)); tlast = 1'($urandom_range(0, 1));
      tready = 1'($urandom_range(0, 1));
      idle(1);
    end
    tvalid = 1'b1; tdata = d; tuser = u; tlast = l; n = 0;
    do begin
      hs = !ready_rand || (n >= 16) || ($urandom_range(0, 1) == 1);
      tready = hs;
      idle(1);
      n++;
    end while (!hs);
    tvalid = 1'b0; tuser = 1'b0; tlast = 1'b0; tready = 1'b0;
  endtask

  task automatic send_line(input int nb, input bit sof, input bit eol);
    for (int b = 0; b < nb; b++) begin
      send_beat(dcnt[23:0], sof && (b == 0), eol && (b == nb - 1));
      dcnt++;
    end
  endtask

  task automatic send_frame(input int nl, input int nb);
    for (int l = 0; l < nl; l++) send_line(nb, l == 0, 1'b1);
  endtask

  initial begin
    vec_t vecs[7];
    int base, ew, eh, exp_fc, last_len, nlines, len;
    bit fok;
    logic [4:0] exp_err;
    longint exp_cs;
    rec_t expq[$];

    vecs[0] = '{8, 4, 4, 8, 8, 4, 1'b1, 5'b00000};
    vecs[1] = '{8, 4, 4, 9, 9, 4, 1'b0, 5'b00010};
    vecs[2] = '{8, 4, 4, 5, 5, 4, 1'b0, 5'b00001};
    vecs[3] = '{8, 4, 2, 8, 8, 2, 1'b0, 5'b00100};
    vecs[4] = '{4, 1, 1, 4, 4, 1, 1'b1, 5'b00000};
    vecs[5] = '{1, 3, 3, 1, 1, 3, 1'b1, 5'b00000};
    vecs[6] = '{6, 2, 2, 6, 6, 2, 1'b1, 5'b00000};

    aresetn = 1'b0; enable = 1'b0; clr_err = 1'b0; tdata = 24'd0;
    tvalid = 1'b0; tready = 1'b0; tuser = 1'b0; tlast = 1'b0;
    exp_width1 = 16'd8; exp_width2 = 16'd8; exp_height = 16'd4;
    idle(2);
    chk("rst_done", done1, 0);
    chk("rst_ok", ok1, 0);
    chk("rst_mw", mw1, 0);
    chk("rst_mh", mh1, 0);
    chk("rst_fc", fc1, 0);
    chk("rst_err", err1, 0);
    chk("rst_cs", cs1, 0);
    chk("rst_fc2", fc2, 0);

    // Single-frame vectors, each from a fresh reset.
    for (int i = 0; i < 7; i++) begin
      do_reset();
      ready_rand = (i % 2) == 1;
      exp_width1 = 16'(vecs[i].ew); exp_height = 16'(vecs[i].eh);
      base = obs1.size();
      send_frame(vecs[i].nl, vecs[i].ll);
      if (vecs[i].nl < vecs[i].eh) send_beat(dcnt[23:0], 1'b1, 1'b0);
      idle(3);
      chk($sformatf("vec%0d_ndone", i), obs1.size() - base, 1);
      chk_rec($sformatf("vec%0d", i), base, vecs[i].mw, vecs[i].mh, vecs[i].ok, 1);
      chk($sformatf("vec%0d_err", i), err1, vecs[i].err);
    end

    // Four clean frames with tready toggling.
    do_reset(); ready_rand = 1'b1; exp_width1 = 16'd8; exp_height = 16'd4;
    base = obs1.size();
    for (int f = 0; f < 4; f++) send_frame(4, 8);
    idle(3);
    chk("clean_ndone", obs1.size() - base, 4);
    for (int f = 0; f < 4; f++) chk_rec($sformatf("clean%0d", f), base + f, 8, 4, 1'b1, f + 1);
    chk("clean_fc", fc1, 4);
    chk("clean_err", err1, 0);

    // PPC=2: 6-pixel second line, then a clean frame, then clear.
    do_reset(); exp_width2 = 16'd8; exp_height = 16'd4;
    send_line(4, 1'b1, 1'b1);
    send_line(3, 1'b0, 1'b1);
    chk("ppc2_short_mw", mw2, 6);
    chk("ppc2_short_err", err2, 5'b00001);
    send_line(4, 1'b0, 1'b1);
    send_line(4, 1'b0, 1'b1);
    idle(2);
    chk("ppc2_bad_ok", ok2, 0);
    chk("ppc2_bad_mh", mh2, 4);
    send_frame(4, 4);
    idle(2);
    chk("ppc2_good_ok", ok2, 1);
    chk("ppc2_good_mw", mw2, 8);
    chk("ppc2_fc", fc2, 2);
    chk("ppc2_err_sticky", err2, 5'b00001);
    clr_err = 1'b1; idle(1); clr_err = 1'b0;
    chk("ppc2_err_clr", err2, 0);

    // Early SOF after two lines; the next frame starts on that SOF beat.
    do_reset(); ready_rand = 1'b1; exp_width1 = 16'd8; exp_height = 16'd4;
    base = obs1.size();
    send_line(8, 1'b1, 1'b1);
    send_line(8, 1'b0, 1'b1);
    send_frame(4, 8);
    idle(3);
    chk("early_ndone", obs1.size() - base, 2);
    chk_rec("early_a", base, 8, 2, 1'b0, 1);
    chk_rec("early_b", base + 1, 8, 4, 1'b1, 2);
    chk("early_err", err1, 5'b00100);

    // Data before the first SOF.
    do_reset(); base = obs1.size();
    for (int k = 0; k < 5; k++) begin
      send_beat(dcnt[23:0], 1'b0, k == 2);
      dcnt++;
    end
    send_frame(4, 8);
    idle(3);
    chk("presof_err", err1, 5'b01000);
    chk("presof_ndone", obs1.size() - base, 1);
    chk_rec("presof", base, 8, 4, 1'b1, 1);

    // Abort via enable, mid-frame reset, clear coincident with a long line.
    do_reset(); ready_rand = 1'b0; exp_width1 = 16'd8; exp_height = 16'd4;
    send_frame(4, 8);
    send_line(8, 1'b1, 1'b1);
    send_line(8, 1'b0, 1'b1);
    send_line(3, 1'b0, 1'b0);
    enable = 1'b0;
    base = obs1.size();
    idle(3);
    chk("abort_ndone", obs1.size() - base, 0);
    chk("abort_fc", fc1, 1);
    chk("abort_mh", mh1, 4);
    enable = 1'b1; idle(1);
    send_frame(4, 8);
    idle(2);
    chk("after_abort_fc", fc1, 2);
    chk("after_abort_ok", ok1, 1);
    send_line(8, 1'b1, 1'b1);
    send_line(4, 1'b0, 1'b0);
    aresetn = 1'b0; idle(1);
    chk("midrst_all", {done1, ok1, mw1, mh1, fc1[15:0], err1}, 0);
    chk("midrst_cs", cs1, 0);
    aresetn = 1'b1; idle(1);
    send_line(7, 1'b1, 1'b1);
    chk("coinc_pre", err1, 5'b00001);
    send_line(8, 1'b0, 1'b0);
    clr_err = 1'b1;
    send_beat(dcnt[23:0], 1'b0, 1'b1);
    clr_err = 1'b0;
    chk("coinc_err", err1, 5'b00010);

    // Checksum over tdata 1..8 of a 4x2 frame.
    do_reset(); ready_rand = 1'b0; exp_width1 = 16'd4; exp_height = 16'd2; dcnt = 1;
    send_frame(2, 4);
    idle(2);
`ifdef AXIS_VIDEO_MON_CHECKSUM_EN
    exp_cs = 36;
`else
    exp_cs = 0;
`endif
    chk("checksum", cs1, exp_cs);

    // Randomized frames against a frame-level model.
    do_reset(); ready_rand = 1'b1;
    ew = $urandom_range(2, 6); eh = $urandom_range(1, 4);
    exp_width1 = 16'(ew); exp_height = 16'(eh);
    base = obs1.size(); exp_fc = 0; exp_err = 5'b00000;
    for (int f = 0; f < 20; f++) begin
      nlines = (f == 19 || $urandom_range(0, 2) != 0) ? eh : $urandom_range(1, eh);
      fok = (nlines == eh);
      last_len = 0;
      for (int k = 0; k < nlines; k++) begin
        len = $urandom_range(ew - 1, ew + 1);
        if (len < 2) len = 2;
        if (len < ew) exp_err[0] = 1'b1;
        if (len > ew) exp_err[1] = 1'b1;
        if (len != ew) fok = 1'b0;
        last_len = len;
        send_line(len, k == 0, 1'b1);
      end
      if (nlines < eh) exp_err[2] = 1'b1;
      exp_fc++;
      expq.push_back('{last_len, nlines, fok, exp_fc});
    end
    idle(3);
    chk("rnd_ndone", obs1.size() - base, expq.size());
    foreach (expq[j]) chk_rec($sformatf("rnd%0d", j), base + j, expq[j].mw, expq[j].mh, expq[j].ok, expq[j].fc);
    chk("rnd_err", err1, exp_err);
    chk("rnd_fc", fc1, exp_fc);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
